// File: rtl/ps2_scan_decoder_if.sv
// Byte stream from the PS/2 frame receiver and the buffered key-event
// handshake toward the keyboard consumer, bundled as one bus.
interface ps2_scan_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic       evt_ready;
  logic       overflow;
  logic       ctrl_seen;

  // Decoder side: consumes bytes, produces events
  modport slave (
    input  rx_data, rx_valid, rx_err, evt_ready,
    output evt_code, evt_ext, evt_break, evt_valid, overflow, ctrl_seen
  );

  // Environment side: drives bytes, accepts events
  modport master (
    output rx_data, rx_valid, rx_err, evt_ready,
    input  evt_code, evt_ext, evt_break, evt_valid, overflow, ctrl_seen
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Collapses PS/2 Set-2 scan-code sequences (E0 / F0 / E1 prefixes) into
// single key events and queues them in a small first-word-fall-through FIFO.
module ps2_scan_decoder #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  ps2_scan_decoder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

  // Keyboard housekeeping bytes that never form a key event
  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [2:0]      skip_q, skip_d;
  logic            ctrl_q, ctrl_d;
  logic            push;
  logic [9:0]      push_word;   // {code, ext, brk}

  // Prefix decode: next state and the event (if any) for this cycle's byte
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    skip_d    = skip_q;
    ctrl_d    = 1'b0;
    push      = 1'b0;
    push_word = {bus.rx_data, 2'b00};
    if (bus.rx_valid) begin
      // Any frame, good or bad, restarts the inactivity timer
      tmo_d = '0;
      if (bus.rx_err) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.rx_data == 8'hE0)      state_d = S_E0;
            else if (bus.rx_data == 8'hF0) state_d = S_F0;
            else if (bus.rx_data == 8'hE1) begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            else if (is_ctrl(bus.rx_data)) ctrl_d = 1'b1;
            else push = 1'b1;
          end
          S_E0: begin
            if (bus.rx_data == 8'hF0) state_d = S_E0F0;
            else if (bus.rx_data != 8'hE0) begin
              push      = 1'b1;
              push_word = {bus.rx_data, 2'b10};
              state_d   = S_IDLE;
            end
          end
          S_F0: begin
            if (bus.rx_data == 8'hE0) state_d = S_E0F0;
            else if (bus.rx_data != 8'hF0) begin
              push      = 1'b1;
              push_word = {bus.rx_data, 2'b01};
              state_d   = S_IDLE;
            end
          end
          S_E0F0: begin
            if ((bus.rx_data != 8'hE0) && (bus.rx_data != 8'hF0)) begin
              push      = 1'b1;
              push_word = {bus.rx_data, 2'b11};
              state_d   = S_IDLE;
            end
          end
          S_PAUSE: begin
            // The Pause key sends E1 plus seven bytes that carry no information
            skip_d = skip_q - 1'b1;
            if (skip_q == 3'd1) begin
              push      = 1'b1;
              push_word = {8'hE1, 2'b00};
              state_d   = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE) begin
      // A stalled partial sequence is abandoned; a byte on the same edge wins
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Decoder state, timeout/skip counters and the registered control pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      skip_q  <= '0;
      ctrl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      skip_q  <= skip_d;
      ctrl_q  <= ctrl_d;
    end
  end

  logic [9:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]   cnt_q;
  logic [9:0]    head_q;
  logic          ovf_q;
  logic          full, empty, pop, wr_en;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign pop     = !empty && bus.evt_ready;
  // A full FIFO still takes a push when the head leaves on the same edge
  assign wr_en   = push && (!full || pop);
  assign rd_next = rd_ptr_q + 1'b1;

  // Event storage; contents need no reset because cnt_q qualifies them
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_word;
  end

  // FIFO pointers, occupancy, sticky overflow and the fall-through head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_next;
      if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
      // Head keeps its last value once the FIFO drains
      if (pop) begin
        if (cnt_q == ONE_CNT) begin
          if (wr_en) head_q <= push_word;
        end else begin
          head_q <= mem_q[rd_next];
        end
      end else if (empty && wr_en) begin
        head_q <= push_word;
      end
    end
  end

  assign bus.evt_code  = head_q[9:2];
  assign bus.evt_ext   = head_q[1];
  assign bus.evt_break = head_q[0];
  assign bus.evt_valid = !empty;
  assign bus.overflow  = ovf_q;
  assign bus.ctrl_seen = ctrl_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder with a queue scoreboard of expected
// key events {code, ext, brk}.
module tb_ps2_scan_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One byte per call; the byte is consumed on the second edge, and the
  // task returns just after that edge.
  task automatic send(input logic [7:0] b, input logic e = 1'b0);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_err   = e;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted event must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_event observed=%h expected=none",
               {bus.evt_code, bus.evt_ext, bus.evt_break});
      end
      if (exp_q.size() > 0) begin
        logic [9:0] exp_w;
        exp_w = exp_q.pop_front();
        checks++;
        assert ({bus.evt_code, bus.evt_ext, bus.evt_break} === exp_w) else begin
          errors++;
          $error("FAIL event observed=%h expected=%h",
                 {bus.evt_code, bus.evt_ext, bus.evt_break}, exp_w);
        end
      end
    end
  end

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.rx_err    = 1'b0;
    bus.evt_ready = 1'b1;
    idle(3);
    rst = 1'b0;

    check("rst_valid", 10'(bus.evt_valid), 10'd0);
    check("rst_head", {bus.evt_code, bus.evt_ext, bus.evt_break}, 10'h000);
    check("rst_ovf", 10'(bus.overflow), 10'd0);
    check("rst_ctrl", 10'(bus.ctrl_seen), 10'd0);

    // Extended make
    send(8'hE0);
    check("e0_alone_valid", 10'(bus.evt_valid), 10'd0);
    exp_q.push_back({8'h75, 2'b10});
    send(8'h75);
    check("e0_75_valid", 10'(bus.evt_valid), 10'd1);
    idle(3);
    check("t1_drained", 10'(exp_q.size()), 10'd0);

    // Make then break
    exp_q.push_back({8'h1C, 2'b00});
    send(8'h1C);
    exp_q.push_back({8'h1C, 2'b01});
    send(8'hF0);
    send(8'h1C);
    idle(3);
    check("t2_drained", 10'(exp_q.size()), 10'd0);

    // Extended break, then the Pause sequence
    exp_q.push_back({8'h75, 2'b11});
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    check("pause_7th_valid", 10'(bus.evt_valid), 10'd0);
    exp_q.push_back({8'hE1, 2'b00});
    send(8'h77);
    check("pause_8th_valid", 10'(bus.evt_valid), 10'd1);
    idle(3);
    check("t3_drained", 10'(exp_q.size()), 10'd0);

    // Overflow with consumer stalled
    bus.evt_ready = 1'b0;
    exp_q.push_back({8'h1C, 2'b00});
    send(8'h1C);
    exp_q.push_back({8'h1B, 2'b00});
    send(8'h1B);
    exp_q.push_back({8'h23, 2'b00});
    send(8'h23);
    exp_q.push_back({8'h2B, 2'b00});
    send(8'h2B);
    send(8'h34);
    check("ovf_valid", 10'(bus.evt_valid), 10'd1);
    check("ovf_flag", 10'(bus.overflow), 10'd1);
    check("ovf_head_stable", {bus.evt_code, bus.evt_ext, bus.evt_break}, {8'h1C, 2'b00});
    bus.evt_ready = 1'b1;
    idle(8);
    check("ovf_drain_valid", 10'(bus.evt_valid), 10'd0);
    check("ovf_sticky", 10'(bus.overflow), 10'd1);
    check("t4_drained", 10'(exp_q.size()), 10'd0);

    // Timeout: 16 idle cycles abandon F0, 15 do not
    exp_q.push_back({8'h1C, 2'b00});
    send(8'hF0);
    idle(15);
    send(8'h1C);
    exp_q.push_back({8'h1C, 2'b01});
    send(8'hF0);
    idle(14);
    send(8'h1C);
    idle(3);
    check("t5_drained", 10'(exp_q.size()), 10'd0);

    // Control byte
    send(8'hAA);
    check("ctrl_pulse", 10'(bus.ctrl_seen), 10'd1);
    check("ctrl_no_event", 10'(bus.evt_valid), 10'd0);
    idle(1);
    check("ctrl_one_cycle", 10'(bus.ctrl_seen), 10'd0);

    // Errored byte abandons the F0 prefix
    exp_q.push_back({8'h1C, 2'b00});
    send(8'hF0);
    send(8'h5A, 1'b1);
    send(8'h1C);
    idle(3);
    check("t6_drained", 10'(exp_q.size()), 10'd0);

    // Reset mid-sequence
    send(8'hE0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_valid", 10'(bus.evt_valid), 10'd0);
    check("rst2_ovf", 10'(bus.overflow), 10'd0);
    check("rst2_head", {bus.evt_code, bus.evt_ext, bus.evt_break}, 10'h000);
    exp_q.push_back({8'h75, 2'b00});
    send(8'h75);
    idle(3);
    check("t7_drained", 10'(exp_q.size()), 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
